core_ifetch_prefetch: RTL and testbench

//  Pipelined instruction fetch unit with prefetch buffer for the RV32I core; replaces the single-shot fetch.

---
 rtl/core_ifetch_pkg.sv | 33 +++
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/core_ifetch_prefetch.sv | 185 ++++++++++++++++++
 tb/tb_core_ifetch_prefetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ifetch_pkg.sv
// ---------------------------------------------------------------------------
// core_ifetch_pkg
// Shared constants and types for the RV32I prefetching instruction fetch unit.
//   AXI_RESP_*       AXI read response codes
//   INSTR_RESET_VAL  instruction word shown to decode while nothing is buffered
//   PC_STEP          sequential fetch increment
//   FIFO_ENTRY_W     width of one prefetch entry {instr, pc[, fault]}
//   ar_state_e       AR channel states (idle / holding a request / holding a
//                    request whose response belongs to a redirected stream)
// Configuration macro: IFETCH_RRESP_CHECK_EN adds the fault bit to each entry.
// ---------------------------------------------------------------------------
package core_ifetch_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

   localparam logic [31:0] INSTR_RESET_VAL = 32'hDEADBEEF;
   localparam logic [31:0] PC_STEP         = 32'd4;

`ifdef IFETCH_RRESP_CHECK_EN
   localparam int FIFO_ENTRY_W = 32 + 32 + 1;
`else
   localparam int FIFO_ENTRY_W = 32 + 32;
`endif

   typedef enum logic [1:0] {
      AR_IDLE,
      AR_HOLD,
      AR_HOLD_STALE
   } ar_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO used as the prefetch buffer.
// The head entry is visible on head_data whenever empty is low.
// Ports:
//   CLK, NRST        clock, synchronous active-low reset
//   push, push_data  write an entry (ignored when full and not popping)
//   pop              consume the head entry (ignored when empty)
//   head_data        current head entry
//   flush            empty the FIFO; wins over push and pop in the same cycle
//   count            number of stored entries
//   full, empty      status flags
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       NRST,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (!NRST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/core_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// core_ifetch_prefetch
// Pipelined instruction fetch with a prefetch buffer. Issues sequential
// AXI4-Lite reads (up to MAX_OUTSTANDING in flight), buffers returned words
// and hands them to decode with valid/ready. A redirect flushes the buffer,
// discards in-flight responses and restarts fetch at the new PC.
// Ports:
//   CLK, NRST                      clock, synchronous active-low reset
//   AXI_AR*                        read address channel (ARADDR = fetch PC)
//   AXI_R*                         read data channel, RREADY high after reset
//   INSTR_VALID/READY              decode handshake on the buffer head
//   INSTRUCTION, INSTR_PC          head word and its PC
//   INSTR_FAULT                    head fetch got a non-OKAY response
//   REDIRECT, REDIRECT_PC          1-cycle restart request and target
//   BUSY                           reads in flight or an AR being presented
// Configuration macro: IFETCH_RRESP_CHECK_EN enables RRESP checking;
// without it RRESP is ignored and INSTR_FAULT is tied low.
// ---------------------------------------------------------------------------
module core_ifetch_prefetch
   import core_ifetch_pkg::*;
#(
   parameter logic [31:0] PC_INIT         = 32'h0,
   parameter int          AXI_AWIDTH      = 32,
   parameter int          AXI_DWIDTH      = 32,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                  CLK,
   input  logic                  NRST,
   output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
   output logic                  AXI_ARVALID,
   input  logic                  AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
   input  logic [1:0]            AXI_RRESP,
   input  logic                  AXI_RVALID,
   output logic                  AXI_RREADY,
   output logic                  INSTR_VALID,
   input  logic                  INSTR_READY,
   output logic [31:0]           INSTRUCTION,
   output logic [31:0]           INSTR_PC,
   output logic                  INSTR_FAULT,
   input  logic                  REDIRECT,
   input  logic [31:0]           REDIRECT_PC,
   output logic                  BUSY
);

   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   ar_state_e             ar_state;
   ar_state_e             ar_state_n;
   logic [31:0]           fpc;
   logic [31:0]           rpc;
   logic [31:0]           araddr_hold;
   logic [31:0]           araddr;
   logic [31:0]           redirect_target;
   logic [OW-1:0]         outstanding;
   logic [OW-1:0]         outstanding_n;
   logic [OW-1:0]         drop;
   logic [OW-1:0]         drop_n;
   logic                  rready;
   logic                  arvalid;
   logic                  issue_ok;
   logic                  ar_hs;
   logic                  stale_hs;
   logic                  r_hs;
   logic                  drop_beat;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FIFO_ENTRY_W-1:0] push_entry;
   logic [FIFO_ENTRY_W-1:0] head_entry;
   logic                  unused_bits;

   assign redirect_target = {REDIRECT_PC[31:2], 2'b00};

   // rready doubles as "out of reset for at least one cycle", so no AR is
   // presented while reset is being applied. Buffer space is reserved at
   // issue time (outstanding + buffered), which is why RREADY can stay high.
   assign issue_ok = rready && !REDIRECT
                     && (int'(outstanding) < MAX_OUTSTANDING)
                     && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);

   always_ff @(posedge CLK) begin
      if (!NRST) ar_state <= AR_IDLE;
      else       ar_state <= ar_state_n;
   end

   // AR channel: a request that was not accepted is held with its captured
   // address. A redirect during the hold marks it stale so that, once it is
   // accepted, its response is added to the drop count.
   always_comb begin
      ar_state_n = ar_state;
      arvalid    = 1'b0;
      araddr     = fpc;
      case (ar_state)
         AR_IDLE: begin
            arvalid = issue_ok;
            if (issue_ok && !AXI_ARREADY) ar_state_n = AR_HOLD;
         end
         AR_HOLD, AR_HOLD_STALE: begin
            arvalid = 1'b1;
            araddr  = araddr_hold;
            if (AXI_ARREADY)   ar_state_n = AR_IDLE;
            else if (REDIRECT) ar_state_n = AR_HOLD_STALE;
         end
         default: ar_state_n = AR_IDLE;
      endcase
   end

   assign ar_hs     = arvalid && AXI_ARREADY;
   assign stale_hs  = ar_hs && (ar_state == AR_HOLD_STALE);
   assign r_hs      = AXI_RVALID && rready;
   assign drop_beat = r_hs && (drop != '0);
   assign push      = r_hs && !drop_beat && !REDIRECT;
   assign pop       = INSTR_VALID && INSTR_READY;

   // On redirect every response still owed after this cycle belongs to the
   // old stream; a held stale AR is not counted yet and adds itself on accept.
   always_comb begin
      outstanding_n = outstanding + OW'(ar_hs) - OW'(r_hs);
      drop_n        = drop - OW'(drop_beat) + OW'(stale_hs);
      if (REDIRECT) drop_n = outstanding_n;
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         fpc         <= PC_INIT;
         rpc         <= PC_INIT;
         araddr_hold <= PC_INIT;
         outstanding <= '0;
         drop        <= '0;
         rready      <= 1'b0;
      end else begin
         outstanding <= outstanding_n;
         drop        <= drop_n;
         rready      <= 1'b1;
         if (ar_state == AR_IDLE && issue_ok) araddr_hold <= fpc;
         if (REDIRECT) begin
            fpc <= redirect_target;
            rpc <= redirect_target;
         end else begin
            if (ar_hs && ar_state != AR_HOLD_STALE) fpc <= fpc + PC_STEP;
            if (push) rpc <= rpc + PC_STEP;
         end
      end
   end

`ifdef IFETCH_RRESP_CHECK_EN
   assign push_entry  = {AXI_RDATA[31:0], rpc, (AXI_RRESP != AXI_RESP_OKAY)};
   assign INSTR_FAULT = !fifo_empty && head_entry[0];
   assign unused_bits = fifo_full;
`else
   assign push_entry  = {AXI_RDATA[31:0], rpc};
   assign INSTR_FAULT = 1'b0;
   assign unused_bits = ^{fifo_full, AXI_RRESP};
`endif

   sync_fifo_fwft #(
      .WIDTH (FIFO_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .NRST      (NRST),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .flush     (REDIRECT),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign AXI_ARADDR  = araddr[AXI_AWIDTH-1:0];
   assign AXI_ARVALID = arvalid;
   assign AXI_RREADY  = rready;
   assign INSTR_VALID = !fifo_empty;
   assign INSTRUCTION = fifo_empty ? INSTR_RESET_VAL : head_entry[FIFO_ENTRY_W-1 -: 32];
   assign INSTR_PC    = fifo_empty ? 32'h0 : head_entry[FIFO_ENTRY_W-33 -: 32];
   assign BUSY        = (outstanding != '0) || arvalid;

endmodule

// File: tb/tb_core_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_core_ifetch_prefetch
// Directed bench for core_ifetch_prefetch with a zero-wait AXI4-Lite memory
// model (responses can be held back) and an in-order decode scoreboard.
// Build with IFETCH_RRESP_CHECK_EN defined to expect the fault flag on PC 0x8.
// ---------------------------------------------------------------------------
module tb_core_ifetch_prefetch;
   import core_ifetch_pkg::*;

   logic        CLK = 1'b0;
   logic        NRST;
   logic [31:0] AXI_ARADDR;
   logic        AXI_ARVALID;
   logic        AXI_ARREADY;
   logic [31:0] AXI_RDATA;
   logic [1:0]  AXI_RRESP;
   logic        AXI_RVALID;
   logic        AXI_RREADY;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [31:0] INSTRUCTION;
   logic [31:0] INSTR_PC;
   logic        INSTR_FAULT;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        BUSY;

   always #5 CLK = ~CLK;

   core_ifetch_prefetch #(
      .PC_INIT         (32'h0),
      .AXI_AWIDTH      (32),
      .AXI_DWIDTH      (32),
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .CLK         (CLK),
      .NRST        (NRST),
      .AXI_ARADDR  (AXI_ARADDR),
      .AXI_ARVALID (AXI_ARVALID),
      .AXI_ARREADY (AXI_ARREADY),
      .AXI_RDATA   (AXI_RDATA),
      .AXI_RRESP   (AXI_RRESP),
      .AXI_RVALID  (AXI_RVALID),
      .AXI_RREADY  (AXI_RREADY),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_PC    (INSTR_PC),
      .INSTR_FAULT (INSTR_FAULT),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .BUSY        (BUSY)
   );

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   logic [31:0] exp_pc;
   logic [31:0] rq[$];
   logic [31:0] ar_log[$];
   bit          rsp_hold;
   logic [31:0] err_addr = 32'h8;

   logic        s_nrst, s_arvalid, s_arready, s_rvalid, s_rready;
   logic        s_ivalid, s_iready, s_ifault, s_busy;
   logic [31:0] s_araddr, s_instr, s_ipc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0BAD_F00D ^ (a << 3);
   endfunction

   function automatic logic exp_fault_for(input logic [31:0] pc);
`ifdef IFETCH_RRESP_CHECK_EN
      return (pc == 32'h8);
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Memory model drive: oldest accepted AR is answered the cycle after accept.
   task automatic driveMem();
      if (rq.size() > 0 && !rsp_hold) begin
         AXI_RVALID = 1'b1;
         AXI_RDATA  = mem_word(rq[0]);
         AXI_RRESP  = (rq[0] == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
         AXI_RVALID = 1'b0;
         AXI_RDATA  = 32'h0;
         AXI_RRESP  = AXI_RESP_OKAY;
      end
   endtask

   task automatic stepCycle();
      driveMem();
      #1;
      s_nrst    = NRST;
      s_arvalid = AXI_ARVALID;
      s_arready = AXI_ARREADY;
      s_araddr  = AXI_ARADDR;
      s_rvalid  = AXI_RVALID;
      s_rready  = AXI_RREADY;
      s_ivalid  = INSTR_VALID;
      s_iready  = INSTR_READY;
      s_instr   = INSTRUCTION;
      s_ipc     = INSTR_PC;
      s_ifault  = INSTR_FAULT;
      s_busy    = BUSY;
      if (s_nrst && s_ivalid && s_iready) begin
         checkOutput("pop_pc", s_ipc, exp_pc);
         checkOutput("pop_data", s_instr, mem_word(exp_pc));
         checkOutput("pop_fault", 32'(s_ifault), 32'(exp_fault_for(exp_pc)));
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      @(posedge CLK);
      if (!s_nrst) begin
         rq.delete();
      end else begin
         if (s_rvalid && s_rready && rq.size() > 0) rq.delete(0);
         if (s_arvalid && s_arready) begin
            rq.push_back(s_araddr);
            ar_log.push_back(s_araddr);
         end
      end
      @(negedge CLK);
   endtask

   // Drives the inputs for 'cycles' cycles; REDIRECT is held for the first only.
   task automatic applyStimulus(input logic nrst, input logic arready,
                                input logic iready, input logic redirect,
                                input logic [31:0] redirect_pc, input int cycles);
      NRST        = nrst;
      AXI_ARREADY = arready;
      INSTR_READY = iready;
      REDIRECT    = redirect;
      REDIRECT_PC = redirect_pc;
      for (int i = 0; i < cycles; i++) begin
         stepCycle();
         REDIRECT = 1'b0;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_arvalid"}, 32'(s_arvalid), 32'h0);
      checkOutput({tag, "_araddr"}, s_araddr, 32'h0);
      checkOutput({tag, "_rready"}, 32'(s_rready), 32'h0);
      checkOutput({tag, "_ivalid"}, 32'(s_ivalid), 32'h0);
      checkOutput({tag, "_instr"}, s_instr, 32'hDEADBEEF);
      checkOutput({tag, "_ipc"}, s_ipc, 32'h0);
      checkOutput({tag, "_fault"}, 32'(s_ifault), 32'h0);
      checkOutput({tag, "_busy"}, 32'(s_busy), 32'h0);
   endtask

   initial begin
      rsp_hold    = 1'b0;
      exp_pc      = 32'h0;
      AXI_RVALID  = 1'b0;
      AXI_RDATA   = 32'h0;
      AXI_RRESP   = 2'b00;

      $display("[TB] reset state");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2);
      checkResetState("rst0");

      $display("[TB] decode stalled: buffer fills, fetch stops");
      exp_pc = 32'h0;
      ar_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 20);
      checkOutput("stall_ar_count", ar_log.size(), 32'd4);
      checkOutput("stall_ar0", ar_log[0], 32'h0);
      checkOutput("stall_ar3", ar_log[3], 32'hC);
      checkOutput("stall_arvalid", 32'(s_arvalid), 32'h0);
      checkOutput("stall_busy", 32'(s_busy), 32'h0);
      checkOutput("stall_ivalid", 32'(s_ivalid), 32'h1);
      checkOutput("stall_head_pc", s_ipc, 32'h0);

      $display("[TB] streaming throughput");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 10);
      pops = 0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 20);
      checkOutput("stream_pops", pops, 32'd20);

      $display("[TB] redirect with two reads outstanding");
      rsp_hold = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4);
      checkOutput("redir_arvalid_limit", 32'(s_arvalid), 32'h0);
      checkOutput("redir_busy", 32'(s_busy), 32'h1);
      checkOutput("redir_buffered", 32'(s_ivalid), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1);
      exp_pc   = 32'h100;
      rsp_hold = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkOutput("redir_flushed", 32'(s_ivalid), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 15);
      checkOutput("redir_progress", 32'(exp_pc >= 32'h120), 32'h1);

      $display("[TB] reset mid-burst");
      rsp_hold = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
      checkOutput("midrst_busy", 32'(s_busy), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2);
      checkResetState("midrst");
      rsp_hold = 1'b0;
      exp_pc   = 32'h0;
      ar_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 15);
      checkOutput("midrst_first_ar", ar_log[0], 32'h0);
      checkOutput("midrst_progress", 32'(exp_pc >= 32'h20), 32'h1);

      $display("[TB] ARREADY stall with redirect");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2);
      ar_log.delete();
      exp_pc = 32'h100;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
      checkOutput("arstall_first", 32'(s_arvalid), 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 1);
         else        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
         checkOutput("arstall_arvalid", 32'(s_arvalid), 32'h1);
         checkOutput("arstall_araddr", s_araddr, 32'h0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 15);
      checkOutput("arstall_stale_ar", ar_log[0], 32'h0);
      checkOutput("arstall_new_ar", ar_log[1], 32'h100);
      checkOutput("arstall_progress", 32'(exp_pc >= 32'h120), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
